edge_window_generator: RTL

Upstream feeder for the edge-detection first/second step cells. Accepts a raster-order stream of binary pixels, one per valid cycle. Buffers two image lines and emits, per interior pixel, the registered 3x3 neighbourhood in the ring ordering the step cells consume. Border pixels produce no window.

---
 rtl/edge_window_generator.sv | 125 ++++++++++++
 1 files changed

// File: rtl/edge_window_generator.sv
// Raster binary-pixel 3x3 window builder: two line buffers plus a 3-column shift window; window registered 1 cycle after its last pixel.
// No backpressure (pixels accepted whenever in_valid); WINDOW_COORD_EN adds registered centre coordinates out_cx/out_cy.
module edge_window_generator #(
  parameter int IMG_WIDTH  = 8,
  parameter int IMG_HEIGHT = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic       in_pixel,
  output logic       out_valid,
  output logic [8:0] neighbors_state,
  output logic       frame_done
`ifdef WINDOW_COORD_EN
  ,
  output logic [$clog2(IMG_WIDTH)-1:0]  out_cx,
  output logic [$clog2(IMG_HEIGHT)-1:0] out_cy
`endif
);

  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);

  logic [CW-1:0]        col_q, col_d;
  logic [RW-1:0]        row_q, row_d;
  logic [IMG_WIDTH-1:0] lb1_q, lb1_d, lb2_q, lb2_d;
  logic [2:0]           sh1_q, sh1_d, sh2_q, sh2_d, new_col;
  logic [8:0]           win, ns_q, ns_d;
  logic                 ov_q, ov_d, fd_q, fd_d;
`ifdef WINDOW_COORD_EN
  logic [CW-1:0]        cx_q, cx_d;
  logic [RW-1:0]        cy_q, cy_d;
`endif

  // Columns are packed {top, mid, bottom}; sh1 is the column left of the incoming one, sh2 two left.
  always_comb begin
    col_d   = col_q;
    row_d   = row_q;
    lb1_d   = lb1_q;
    lb2_d   = lb2_q;
    sh1_d   = sh1_q;
    sh2_d   = sh2_q;
    ov_d    = 1'b0;
    fd_d    = 1'b0;
    ns_d    = ns_q;
`ifdef WINDOW_COORD_EN
    cx_d    = cx_q;
    cy_d    = cy_q;
`endif
    new_col = {lb2_q[col_q], lb1_q[col_q], in_pixel};
    win     = {sh1_q[1], sh2_q[1], sh2_q[0], sh1_q[0], new_col[0],
               new_col[1], new_col[2], sh1_q[2], sh2_q[2]};

    if (in_valid) begin
      lb1_d[col_q] = in_pixel;
      lb2_d[col_q] = lb1_q[col_q];
      sh2_d        = sh1_q;
      sh1_d        = new_col;

      if (col_q == COL_LAST) begin
        col_d = '0;
        row_d = (row_q == ROW_LAST) ? '0 : row_q + RW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end

      // Columns 0-1 of each row only prime the shift window, so no window crosses a line boundary.
      if (col_q >= CW'(2) && row_q >= RW'(2)) begin
        ov_d = 1'b1;
        ns_d = win;
`ifdef WINDOW_COORD_EN
        cx_d = col_q - CW'(1);
        cy_d = row_q - RW'(1);
`endif
      end

      fd_d = (col_q == COL_LAST) && (row_q == ROW_LAST);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col_q <= '0;
      row_q <= '0;
      sh1_q <= '0;
      sh2_q <= '0;
      ov_q  <= 1'b0;
      fd_q  <= 1'b0;
      ns_q  <= '0;
`ifdef WINDOW_COORD_EN
      cx_q  <= '0;
      cy_q  <= '0;
`endif
    end else begin
      col_q <= col_d;
      row_q <= row_d;
      sh1_q <= sh1_d;
      sh2_q <= sh2_d;
      ov_q  <= ov_d;
      fd_q  <= fd_d;
      ns_q  <= ns_d;
`ifdef WINDOW_COORD_EN
      cx_q  <= cx_d;
      cy_q  <= cy_d;
`endif
    end
  end

  // Rows 0-1 are rewritten every frame before any window reads them, so no reset is needed.
  always_ff @(posedge clk) begin
    lb1_q <= lb1_d;
    lb2_q <= lb2_d;
  end

  assign out_valid       = ov_q;
  assign neighbors_state = ns_q;
  assign frame_done      = fd_q;
`ifdef WINDOW_COORD_EN
  assign out_cx          = cx_q;
  assign out_cy          = cy_q;
`endif

endmodule
